// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI link between NREQ requesters, sending each word LSB-first.
// Optional SPI_DONE_CHECK_EN: sample the slave done flag at the end of the frame and pulse err with ack if it is missing.
module spi_master_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 12,
   parameter int CLK_DIV = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*DW-1:0]  wdata,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     ack,
   output logic                err,
   output logic                busy,
   output logic                sclk,
   output logic                cs_n,
   output logic                mosi,
   input  logic                slv_done
);
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW   = $clog2(2*CLK_DIV + 1);
   localparam int NPER = DW + 2;               // setup + data + done periods
   localparam int BW   = $clog2(NPER + 1);

   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   rr_ptr, rr_nx, win;
   logic            win_vld;
   logic [DW-1:0]   sr, sr_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [BW-1:0]   per, per_nx;
   logic [NREQ-1:0] gnt_nx, ack_nx;
   logic            err_nx, busy_nx, sclk_nx, cs_n_nx, mosi_nx;
   logic            done_miss;
   logic [DW-1:0]   words [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_words
      assign words[g] = wdata[g*DW +: DW];
   end

`ifdef SPI_DONE_CHECK_EN
   assign done_miss = ~slv_done;
`else
   logic slv_done_unused;
   assign slv_done_unused = slv_done;
   assign done_miss = 1'b0;
`endif

   // Scan downward so the closest set bit after rr_ptr is the one left standing.
   always_comb begin
      int idx;
      win     = rr_ptr;
      win_vld = 1'b0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[PW'(idx)]) begin
            win     = PW'(idx);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      rr_nx    = rr_ptr;
      sr_nx    = sr;
      cnt_nx   = cnt;
      per_nx   = per;
      gnt_nx   = '0;
      ack_nx   = '0;
      err_nx   = 1'b0;
      busy_nx  = busy;
      sclk_nx  = sclk;
      cs_n_nx  = cs_n;
      mosi_nx  = mosi;
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nx    = XFER;
               rr_nx       = win;
               sr_nx       = words[win];
               gnt_nx[win] = 1'b1;
               cnt_nx      = '0;
               per_nx      = '0;
               cs_n_nx     = 1'b0;
               busy_nx     = 1'b1;
               sclk_nx     = 1'b0;
               mosi_nx     = 1'b0;
            end
         end
         XFER: begin
            if (cnt == CW'(CLK_DIV-1)) begin
               cnt_nx = '0;
               if (!sclk) begin
                  sclk_nx = 1'b1;
               end else if (per == BW'(NPER-1)) begin
                  state_nx       = GAP;
                  ack_nx[rr_ptr] = 1'b1;
                  err_nx         = done_miss;
                  cs_n_nx        = 1'b1;
                  sclk_nx        = 1'b0;
                  mosi_nx        = 1'b0;
               end else begin
                  // period per+1 carries data bit per; setup and done periods send 0
                  sclk_nx = 1'b0;
                  per_nx  = per + 1'b1;
                  if (per < BW'(DW)) begin
                     mosi_nx = sr[0];
                     sr_nx   = sr >> 1;
                  end else begin
                     mosi_nx = 1'b0;
                  end
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == CW'(2*CLK_DIV-1)) begin
               state_nx = IDLE;
               busy_nx  = 1'b0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= PW'(NREQ-1);
         sr     <= '0;
         cnt    <= '0;
         per    <= '0;
         gnt    <= '0;
         ack    <= '0;
         err    <= 1'b0;
         busy   <= 1'b0;
         sclk   <= 1'b0;
         cs_n   <= 1'b1;
         mosi   <= 1'b0;
      end else begin
         state  <= state_nx;
         rr_ptr <= rr_nx;
         sr     <= sr_nx;
         cnt    <= cnt_nx;
         per    <= per_nx;
         gnt    <= gnt_nx;
         ack    <= ack_nx;
         err    <= err_nx;
         busy   <= busy_nx;
         sclk   <= sclk_nx;
         cs_n   <= cs_n_nx;
         mosi   <= mosi_nx;
      end
   end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: random requesters, a behavioural SPI slave and a cycle-level scoreboard.
`timescale 1ns/1ps
module tb_spi_master_arbiter;
   localparam int NREQ     = 4;
   localparam int DW       = 12;
   localparam int CD       = 2;
   localparam int XFER_CYC = 28*CD;
   localparam int SPACING  = 30*CD + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*DW-1:0] wdata = '0;
   logic [NREQ-1:0]   gnt, ack;
   logic              err, busy, sclk, cs_n, mosi, slv_done;

   spi_master_arbiter #(.NREQ(NREQ), .DW(DW), .CLK_DIV(CD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
      .err(err), .busy(busy), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .slv_done(slv_done)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Slave: rise 0 clears done, rises 1..DW shift in LSB first, rise DW+1 publishes word and done.
   int          rise_cnt = 0;
   logic [DW-1:0] s_sr = '0, s_dout;
   logic        s_done = 1'b0, done_stuck = 1'b0;
   assign slv_done = s_done & ~done_stuck;

   initial forever begin
      @(posedge sclk or posedge cs_n);
      if (cs_n) rise_cnt = 0;
      else begin
         if (rise_cnt == 0) s_done = 1'b0;
         else if (rise_cnt <= DW) s_sr = {mosi, s_sr[DW-1:1]};
         else if (rise_cnt == DW+1) begin s_dout = s_sr; s_done = 1'b1; end
         rise_cnt++;
      end
   end

   typedef struct {int idx; logic [DW-1:0] word; int due;} txn_t;
   txn_t            sb[$];
   int              ack_num[NREQ];
   logic [NREQ-1:0] granted = '0;

   // Monitor: one look per cycle just after the edge; model owns arbitration order and frame timing.
   initial begin
      int m_rr, next_ok, w, c, st, off, p;
      logic [NREQ-1:0] e_gnt, e_ack;
      logic e_err, e_busy, e_cs, e_sclk, e_mosi;
      logic [DW-1:0] cw;
      txn_t t;
      m_rr = NREQ-1; next_ok = 0;
      for (int i = 0; i < NREQ; i++) ack_num[i] = 0;
      forever begin
         @(posedge clk); #1; cyc++;
         e_gnt = '0; e_ack = '0; e_err = 1'b0;
         e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
         if (!rst_n) begin
            sb.delete(); m_rr = NREQ-1; next_ok = cyc + 1; granted = '0;
            chk("reset_outs", {gnt, ack, err, busy, cs_n, sclk, mosi},
                {e_gnt, e_ack, e_err, 1'b0, e_cs, e_sclk, e_mosi});
            continue;
         end
         if (cyc >= next_ok && req != '0) begin
            w = m_rr;
            for (int s = 1; s <= NREQ; s++) begin
               c = (m_rr + s) % NREQ;
               if (req[c]) begin w = c; break; end
            end
            e_gnt[w] = 1'b1;
            t.idx = w; t.word = wdata[w*DW +: DW]; t.due = cyc + XFER_CYC;
            sb.push_back(t);
            m_rr = w; next_ok = cyc + SPACING; granted[w] = 1'b1;
         end
         e_busy = (cyc < next_ok - 1);
         if (sb.size() > 0) begin
            st = sb[0].due - XFER_CYC;
            if (cyc < sb[0].due) begin
               off = cyc - st; p = off / (2*CD); cw = sb[0].word;
               e_cs = 1'b0;
               e_sclk = ((off % (2*CD)) >= CD);
               if (p >= 1 && p <= DW) e_mosi = cw[p-1];
            end else begin
               e_ack[sb[0].idx] = 1'b1;
`ifdef SPI_DONE_CHECK_EN
               e_err = done_stuck;
`else
               e_err = 1'b0;
`endif
               chk("slave_dout", s_dout, sb[0].word);
               ack_num[sb[0].idx]++;
               granted[sb[0].idx] = 1'b0;
               t = sb.pop_front();
            end
         end
         chk("outs{gnt,ack,err,busy,cs_n,sclk,mosi}", {gnt, ack, err, busy, cs_n, sclk, mosi},
             {e_gnt, e_ack, e_err, e_busy, e_cs, e_sclk, e_mosi});
      end
   end

   int drv_ack[NREQ];
   int hold_mode = 0;   // 0 drop req on ack, 1 keep, 2 random

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (ack_num[i] != drv_ack[i]) begin
         drv_ack[i] = ack_num[i];
         if (hold_mode == 1 || (hold_mode == 2 && $urandom_range(0, 1) == 1))
            wdata[i*DW +: DW] = DW'($urandom);
         else
            req[i] = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      hold_mode = 0;
      while ((req != '0 || busy) && n < 3000) begin step(); n++; end
      chk("drain_timeout", req, '0);
      repeat (4) step();
   endtask

   task automatic apply_reset();
      req = '0;
      @(negedge clk); rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   initial begin
      int n, a1;
      for (int i = 0; i < NREQ; i++) drv_ack[i] = 0;
      apply_reset();
      // single requester, known word
      wdata[0 +: DW] = 12'hA5C; req = 4'b0001;
      drain();
      // all four held from reset: round robin 0,1,2,3,0,...
      apply_reset();
      wdata = {12'h9C3, 12'h5E7, 12'h2B1, 12'hF08};
      hold_mode = 1; req = 4'b1111;
      repeat (5*SPACING + 5) step();
      drain();
      // request arriving during GAP waits for IDLE
      wdata[1*DW +: DW] = 12'h6D2; req = 4'b0010;
      a1 = drv_ack[1]; n = 0;
      while (drv_ack[1] == a1 && n < 500) begin step(); n++; end
      chk("gap_ack_timeout", drv_ack[1] != a1, 1'b1);
      wdata[2*DW +: DW] = 12'h5A3; req[2] = 1'b1;
      drain();
      // reset mid-transfer around p=6
      wdata[0 +: DW] = 12'h0F0; req = 4'b0001;
      n = 0;
      while (!granted[0] && n < 500) begin step(); n++; end
      chk("gnt_timeout", granted[0], 1'b1);
      repeat (6*2*CD) step();
      rst_n = 1'b0; #1;
      chk("async_reset{cs_n,sclk,busy}", {cs_n, sclk, busy}, 3'b100);
      step();
      wdata[0 +: DW] = 12'h7E1;
      step();
      rst_n = 1'b1;
      drain();
      // slave never reports done
      done_stuck = 1'b1;
      wdata[0 +: DW] = 12'h3A5; wdata[3*DW +: DW] = 12'hC4D; req = 4'b1001;
      drain();
      done_stuck = 1'b0;
      // boundary words
      wdata[1*DW +: DW] = 12'hFFF; wdata[2*DW +: DW] = 12'h001; req = 4'b0110;
      drain();
      // random traffic
      hold_mode = 2;
      for (int it = 0; it < 1500; it++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 19) == 0) begin
               wdata[i*DW +: DW] = DW'($urandom); req[i] = 1'b1;
            end else if (req[i] && !granted[i] && $urandom_range(0, 49) == 0) begin
               req[i] = 1'b0;
            end
            if (granted[i] && $urandom_range(0, 9) == 0) wdata[i*DW +: DW] = DW'($urandom);
         end
      end
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
